// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// write-path FSM state encodings and the burst length.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   localparam int BURST_LEN = 4;

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_REQ  = 5'b00010,
      S_ACT  = 5'b00100,
      S_WR   = 5'b01000,
      S_PRE  = 5'b10000
   } wr_state_t;

endpackage

// File: rtl/sdram_write.sv
// SDRAM write-path command generator for bank 0: ACT, back-to-back burst-of-4
// WRITEs and PRE, filling rows 0..LAST_ROW and yielding to refresh per burst.
module sdram_write
   import sdram_pkg::*;
#(
   parameter int ROW_W    = 12,
   parameter int COL_W    = 9,
   parameter int DATA_W   = 16,
   parameter int ACT_WAIT = 3,
   parameter int PRE_WAIT = 3,
   parameter int LAST_ROW = 2
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              wr_trig,
   input  logic              wr_en,
   input  logic              ref_req,
   output logic              wr_req,
   output logic              flag_wr_end,
   output logic [3:0]        wr_cmd,
   output logic [ROW_W-1:0]  wr_addr,
   output logic [1:0]        bank_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_dq_oe,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout
);

   localparam int ACT_CNT_W = (ACT_WAIT > 0) ? $clog2(ACT_WAIT + 1) : 1;
   localparam int PRE_CNT_W = (PRE_WAIT > 0) ? $clog2(PRE_WAIT + 1) : 1;
   localparam logic [ACT_CNT_W-1:0] ACT_LAST     = ACT_CNT_W'(ACT_WAIT);
   localparam logic [PRE_CNT_W-1:0] PRE_LAST     = PRE_CNT_W'(PRE_WAIT);
   localparam logic [1:0]           BURST_LAST   = 2'(BURST_LEN - 1);
   localparam logic [COL_W-1:0]     COL_STEP     = COL_W'(BURST_LEN);
   localparam logic [ROW_W-1:0]     ROW_LAST     = ROW_W'(LAST_ROW);
   localparam logic [ROW_W-1:0]     PRE_ALL_ADDR = ROW_W'(11'h400);

   wr_state_t state_r;
   wr_state_t state_nxt_s;

   logic [ACT_CNT_W-1:0] act_cnt_r;
   logic [PRE_CNT_W-1:0] pre_cnt_r;
   logic [1:0]           burst_cnt_r;
   logic [ROW_W-1:0]     row_r;
   logic [COL_W-1:0]     col_r;
   logic                 done_r;
   logic                 yield_r;

   logic                 act_end_s;
   logic                 burst_end_s;
   logic                 pre_end_s;
   logic                 last_col_s;
   logic                 last_row_s;
   logic                 release_s;
   logic [ROW_W-1:0]     col_addr_s;

   assign act_end_s   = (state_r == S_ACT) && (act_cnt_r == ACT_LAST);
   assign burst_end_s = (state_r == S_WR) && (burst_cnt_r == BURST_LAST);
   assign pre_end_s   = (state_r == S_PRE) && (pre_cnt_r == PRE_LAST);
   assign last_col_s  = &col_r[COL_W-1:2];
   assign last_row_s  = (row_r == ROW_LAST);
   assign release_s   = pre_end_s && (done_r || yield_r || ref_req);
   // Column address keeps A10 low so the WRITE does not auto-precharge.
   assign col_addr_s  = ROW_W'({col_r[COL_W-1:2], 2'b00});

   assign wr_req     = (state_r == S_REQ);
   assign fifo_rd_en = (state_r == S_WR);
   assign bank_addr  = 2'b00;

   // State register.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (wr_trig) state_nxt_s = S_REQ;
            else         state_nxt_s = S_IDLE;
         end
         S_REQ: begin
            if (wr_en) state_nxt_s = S_ACT;
            else       state_nxt_s = S_REQ;
         end
         S_ACT: begin
            if (act_end_s) state_nxt_s = S_WR;
            else           state_nxt_s = S_ACT;
         end
         S_WR: begin
            if (burst_end_s && (last_col_s || ref_req)) state_nxt_s = S_PRE;
            else                                        state_nxt_s = S_WR;
         end
         S_PRE: begin
            if (!pre_end_s)              state_nxt_s = S_PRE;
            else if (done_r)             state_nxt_s = S_IDLE;
            else if (yield_r || ref_req) state_nxt_s = S_REQ;
            else                         state_nxt_s = S_ACT;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Phase counters run only while their state is held, so they restart at 0 on entry.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         act_cnt_r   <= {ACT_CNT_W{1'b0}};
         pre_cnt_r   <= {PRE_CNT_W{1'b0}};
         burst_cnt_r <= 2'd0;
      end else begin
         act_cnt_r   <= (state_r == S_ACT && state_nxt_s == S_ACT) ?
                        act_cnt_r + ACT_CNT_W'(1) : {ACT_CNT_W{1'b0}};
         pre_cnt_r   <= (state_r == S_PRE && state_nxt_s == S_PRE) ?
                        pre_cnt_r + PRE_CNT_W'(1) : {PRE_CNT_W{1'b0}};
         burst_cnt_r <= (state_r == S_WR) ? burst_cnt_r + 2'd1 : 2'd0;
      end
   end

   // Job progress: row/column position, completion and refresh-yield flags.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         row_r   <= {ROW_W{1'b0}};
         col_r   <= {COL_W{1'b0}};
         done_r  <= 1'b0;
         yield_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (wr_trig) begin
                  row_r   <= {ROW_W{1'b0}};
                  col_r   <= {COL_W{1'b0}};
                  done_r  <= 1'b0;
                  yield_r <= 1'b0;
               end
            end
            S_WR: begin
               // Row end takes priority over refresh; refresh is re-checked at PRE exit.
               if (burst_end_s) begin
                  if (last_col_s) begin
                     col_r <= {COL_W{1'b0}};
                     if (last_row_s) done_r <= 1'b1;
                     else            row_r  <= row_r + ROW_W'(1);
                  end else begin
                     col_r <= col_r + COL_STEP;
                     if (ref_req) yield_r <= 1'b1;
                  end
               end
            end
            S_PRE: begin
               if (pre_end_s) yield_r <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Registered command, address and data outputs, one cycle behind the FSM.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_cmd      <= CMD_NOP;
         wr_addr     <= {ROW_W{1'b0}};
         wr_data     <= {DATA_W{1'b0}};
         wr_dq_oe    <= 1'b0;
         flag_wr_end <= 1'b0;
      end else begin
         wr_cmd      <= CMD_NOP;
         wr_data     <= {DATA_W{1'b0}};
         wr_dq_oe    <= 1'b0;
         flag_wr_end <= release_s;
         case (state_r)
            S_ACT: begin
               if (act_cnt_r == {ACT_CNT_W{1'b0}}) begin
                  wr_cmd  <= CMD_ACT;
                  wr_addr <= row_r;
               end
            end
            S_WR: begin
               wr_data  <= fifo_dout;
               wr_dq_oe <= 1'b1;
               if (burst_cnt_r == 2'd0) begin
                  wr_cmd  <= CMD_WR;
                  wr_addr <= col_addr_s;
               end
            end
            S_PRE: begin
               if (pre_cnt_r == {PRE_CNT_W{1'b0}}) begin
                  wr_cmd  <= CMD_PRE;
                  wr_addr <= PRE_ALL_ADDR;
               end
            end
            default: wr_addr <= {ROW_W{1'b0}};
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: a vector table for the first transaction plus
// hand-written sequences for full job, refresh yields, ignored trigger and reset.
module tb_sdram_write;

   localparam logic [3:0] T_NOP = 4'b0111;
   localparam logic [3:0] T_ACT = 4'b0011;
   localparam logic [3:0] T_WR  = 4'b0100;
   localparam logic [3:0] T_PRE = 4'b0010;

   logic        sclk     = 1'b0;
   logic        s_rst_n  = 1'b0;
   logic        wr_trig  = 1'b0;
   logic        wr_en    = 1'b0;
   logic        ref_req  = 1'b0;
   logic        wr_req;
   logic        flag_wr_end;
   logic [3:0]  wr_cmd;
   logic [11:0] wr_addr;
   logic [1:0]  bank_addr;
   logic [15:0] wr_data;
   logic        wr_dq_oe;
   logic        fifo_rd_en;
   logic [15:0] fifo_dout;
   logic [15:0] fifo_val = 16'd1;

   int n_checks = 0;
   int n_errors = 0;

   bit          mon_en = 1'b0;
   int          exp_row, exp_col;
   logic [15:0] exp_data;
   int          n_act, n_wr, n_pre, n_beats, n_flag;
   int          last_act, last_wr;

   typedef struct packed {
      logic        trig;
      logic        en;
      logic        exp_req;
      logic [3:0]  exp_cmd;
      logic        chk_addr;
      logic [11:0] exp_addr;
      logic        exp_rd;
      logic        exp_oe;
      logic        chk_data;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [16];

   sdram_write dut (
      .sclk        (sclk),
      .s_rst_n     (s_rst_n),
      .wr_trig     (wr_trig),
      .wr_en       (wr_en),
      .ref_req     (ref_req),
      .wr_req      (wr_req),
      .flag_wr_end (flag_wr_end),
      .wr_cmd      (wr_cmd),
      .wr_addr     (wr_addr),
      .bank_addr   (bank_addr),
      .wr_data     (wr_data),
      .wr_dq_oe    (wr_dq_oe),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_dout   (fifo_dout)
   );

   always #5 sclk = ~sclk;

   // First-word-fall-through FIFO holding 1,2,3,...
   assign fifo_dout = fifo_val;
   always @(posedge sclk) if (fifo_rd_en) fifo_val <= fifo_val + 16'd1;

   function automatic vec_t mk(input logic trig, input logic en, input logic req,
                               input logic [3:0] cmd, input logic ca, input logic [11:0] addr,
                               input logic rd, input logic oe, input logic cd,
                               input logic [15:0] d);
      return {trig, en, req, cmd, ca, addr, rd, oe, cd, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon_reset();
      exp_row  = 0;
      exp_col  = 0;
      exp_data = fifo_val;
      n_act = 0; n_wr = 0; n_pre = 0; n_beats = 0; n_flag = 0;
      last_act = -1; last_wr = -1;
   endtask

   // Advance one clock and sample; the monitor models row/column progress and data order.
   task automatic tick();
      @(posedge sclk);
      #1;
      if (mon_en) begin
         if (flag_wr_end) n_flag++;
         if (wr_dq_oe) begin
            check("wr_data_seq", 32'(wr_data), 32'(exp_data));
            exp_data = exp_data + 16'd1;
            n_beats++;
         end
         case (wr_cmd)
            T_ACT: begin
               n_act++;
               last_act = 32'(wr_addr);
               check("act_addr", 32'(wr_addr), 32'(exp_row));
            end
            T_WR: begin
               n_wr++;
               last_wr = 32'(wr_addr);
               check("wr_oe_with_cmd", 32'(wr_dq_oe), 32'd1);
               check("wr_col_addr", 32'(wr_addr), 32'(exp_col));
               exp_col = exp_col + 4;
               if (exp_col == 512) begin
                  exp_col = 0;
                  exp_row = exp_row + 1;
               end
            end
            T_PRE: begin
               n_pre++;
               check("pre_addr", 32'(wr_addr), 32'h400);
            end
            default: begin
            end
         endcase
      end
   endtask

   task automatic wait_flag(input string name, input int budget);
      int i;
      i = 0;
      while (!flag_wr_end && i < budget) begin
         tick();
         i++;
      end
      check(name, 32'(flag_wr_end), 32'd1);
   endtask

   task automatic wait_wr(input string name, input int addr, input int budget);
      int  i;
      bit  hit;
      i   = 0;
      hit = (wr_cmd == T_WR) && (addr < 0 || 32'(wr_addr) == addr);
      while (!hit && i < budget) begin
         tick();
         i++;
         hit = (wr_cmd == T_WR) && (addr < 0 || 32'(wr_addr) == addr);
      end
      check(name, 32'(hit), 32'd1);
   endtask

   task automatic grant();
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd"},  32'(wr_cmd),      32'(T_NOP));
      check({tag, "_addr"}, 32'(wr_addr),     32'd0);
      check({tag, "_data"}, 32'(wr_data),     32'd0);
      check({tag, "_oe"},   32'(wr_dq_oe),    32'd0);
      check({tag, "_flag"}, 32'(flag_wr_end), 32'd0);
      check({tag, "_req"},  32'(wr_req),      32'd0);
      check({tag, "_rd"},   32'(fifo_rd_en),  32'd0);
      check({tag, "_bank"}, 32'(bank_addr),   32'd0);
   endtask

   initial begin
      int saved_wr;

      // trig en req cmd ca addr rd oe cd data
      vecs[0]  = mk(1'b1, 1'b0, 1'b1, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[1]  = mk(1'b0, 1'b0, 1'b1, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[5]  = mk(1'b0, 1'b1, 1'b0, T_NOP, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, T_ACT, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
      vecs[10] = mk(1'b0, 1'b0, 1'b0, T_WR,  1'b1, 12'h000, 1'b1, 1'b1, 1'b1, 16'd1);
      vecs[11] = mk(1'b1, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 16'd2);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 16'd3);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 16'd4);
      vecs[14] = mk(1'b0, 1'b0, 1'b0, T_WR,  1'b1, 12'h004, 1'b1, 1'b1, 1'b1, 16'd5);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, T_NOP, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 16'd6);

      // Reset state
      repeat (3) tick();
      check_reset_outputs("reset");
      s_rst_n = 1'b1;
      tick();

      // First transaction, table-driven; wr_trig re-pulsed during WR must be ignored
      mon_reset();
      mon_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_trig = vecs[i].trig;
         wr_en   = vecs[i].en;
         tick();
         check($sformatf("vec%0d_req", i), 32'(wr_req),     32'(vecs[i].exp_req));
         check($sformatf("vec%0d_cmd", i), 32'(wr_cmd),     32'(vecs[i].exp_cmd));
         check($sformatf("vec%0d_rd", i),  32'(fifo_rd_en), 32'(vecs[i].exp_rd));
         check($sformatf("vec%0d_oe", i),  32'(wr_dq_oe),   32'(vecs[i].exp_oe));
         if (vecs[i].chk_addr)
            check($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
         if (vecs[i].chk_data)
            check($sformatf("vec%0d_data", i), 32'(wr_data), 32'(vecs[i].exp_data));
      end
      wr_trig = 1'b0;
      wr_en   = 1'b0;

      // Rest of the full job, no refresh
      wait_flag("job1_flag", 5000);
      check("job1_req_at_end", 32'(wr_req), 32'd0);
      check("job1_n_act",   32'(n_act),   32'd3);
      check("job1_n_wr",    32'(n_wr),    32'd384);
      check("job1_n_pre",   32'(n_pre),   32'd3);
      check("job1_n_beats", 32'(n_beats), 32'd1536);
      repeat (20) tick();
      check("job1_single_flag", 32'(n_flag), 32'd1);
      check("job1_no_second_job", 32'(n_act), 32'd3);
      check("job1_idle_req", 32'(wr_req), 32'd0);

      // Refresh request during the burst at column 40
      mon_reset();
      wr_trig = 1'b1;
      tick();
      wr_trig = 1'b0;
      check("job2_req", 32'(wr_req), 32'd1);
      grant();
      wait_wr("job2_wr_col40", 40, 300);
      ref_req = 1'b1;
      wait_flag("yield40_flag", 50);
      ref_req = 1'b0;
      check("yield40_req", 32'(wr_req), 32'd1);
      check("yield40_n_wr", 32'(n_wr), 32'd11);
      check("yield40_n_pre", 32'(n_pre), 32'd1);
      check("yield40_beats", 32'(n_beats), 32'd44);
      grant();
      wait_wr("resume44_wr", -1, 50);
      check("resume44_act_row", 32'(last_act), 32'd0);
      check("resume44_col", 32'(last_wr), 32'd44);

      // Refresh coincident with the last burst of row 0
      wait_wr("job2_wr_col508", 508, 1000);
      ref_req = 1'b1;
      wait_flag("rowend_flag", 50);
      ref_req = 1'b0;
      check("rowend_req", 32'(wr_req), 32'd1);
      check("rowend_n_wr", 32'(n_wr), 32'd128);
      check("rowend_n_pre", 32'(n_pre), 32'd2);
      grant();
      wait_wr("row1_wr", -1, 50);
      check("row1_act_row", 32'(last_act), 32'd1);
      check("row1_col", 32'(last_wr), 32'd0);

      // Reset in the middle of a burst
      wait_wr("job2_wr_col8", 8, 100);
      s_rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (3) tick();
      s_rst_n = 1'b1;
      saved_wr = n_wr;
      repeat (30) tick();
      check("midrst_no_wr", 32'(n_wr), 32'(saved_wr));
      check("midrst_idle_req", 32'(wr_req), 32'd0);
      check("midrst_idle_cmd", 32'(wr_cmd), 32'(T_NOP));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
